// File: rtl/fcb_pkg.sv
// Shared types and helpers for the flow-controlled buffer (fcb) family.
package fcb_pkg;

    // Skid-buffer occupancy state; encoding 2'd3 is unused and behaves as EMPTY.
    typedef enum logic [1:0] {
        FCB_EMPTY = 2'd0,
        FCB_BUSY  = 2'd1,
        FCB_FULL  = 2'd2
    } fcb_skid_state_t;

    // Handshake-side view of a skid state.
    typedef struct packed {
        logic       down_vld;
        logic       up_rdy;
        logic [1:0] occupancy;
    } fcb_skid_flags_t;

    // Decode the registered state into the flags seen on the ports.
    function automatic fcb_skid_flags_t fcb_skid_decode(input fcb_skid_state_t s);
        fcb_skid_flags_t f;
        // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
        f.down_vld  = 1'b0;
        f.up_rdy    = 1'b1;
        f.occupancy = 2'd0;
        case (s)
            FCB_BUSY: begin
                f.down_vld  = 1'b1;
                f.up_rdy    = 1'b1;
                f.occupancy = 2'd1;
            end
            FCB_FULL: begin
                f.down_vld  = 1'b1;
                f.up_rdy    = 1'b0;
                f.occupancy = 2'd2;
            end
            default: ; // EMPTY and the unused encoding
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fcb_2_skid_registered_rdy.sv
// Two-entry skid buffer: registers both the forward (valid/data) and the
// backward (ready) paths so long ready chains can be broken.
module fcb_2_skid_registered_rdy
    import fcb_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [w-1:0] up_data,
    output logic         down_vld,
    input  logic         down_rdy,
    output logic [w-1:0] down_data,
    output logic [1:0]   occupancy
);

    fcb_skid_state_t r_state;
    logic [w-1:0]    r_main;
    logic [w-1:0]    r_skid;

    fcb_skid_flags_t w_flags;
    logic            w_up_fire;
    logic            w_down_fire;

    // Port flags are a pure decode of the state flop, so up_rdy never sees down_rdy.
    assign w_flags     = fcb_skid_decode(r_state);
    assign up_rdy      = w_flags.up_rdy;
    assign down_vld    = w_flags.down_vld;
    assign occupancy   = w_flags.occupancy;
    assign down_data   = r_main;

    assign w_up_fire   = up_vld & w_flags.up_rdy;
    assign w_down_fire = w_flags.down_vld & down_rdy;

    // State and data update: main feeds the output, skid catches the word arriving during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: only two data words, so they are cleared on reset for a deterministic down_data.
            r_state <= FCB_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                FCB_BUSY: begin
                    if (w_up_fire && w_down_fire) begin
                        r_main <= up_data;
                    end else if (w_up_fire) begin
                        r_skid  <= up_data;
                        r_state <= FCB_FULL;
                    end else if (w_down_fire) begin
                        r_state <= FCB_EMPTY;
                    end
                end
                FCB_FULL: begin
                    // up_rdy is low here, so nothing is accepted from upstream.
                    if (w_down_fire) begin
                        r_main  <= r_skid;
                        r_state <= FCB_BUSY;
                    end
                end
                default: begin
                    // EMPTY, and the unused encoding recovers as EMPTY.
                    if (w_up_fire) begin
                        r_main  <= up_data;
                        r_state <= FCB_BUSY;
                    end
                end
            endcase
        end
    end

    // Upstream must never be accepted while both entries are occupied.
    a_no_accept_when_full : assert property (
        @(posedge clk) disable iff (rst) !((r_state == FCB_FULL) && up_vld && up_rdy)
    );

endmodule

// File: tb/tb_fcb_2_skid_registered_rdy.sv
// Randomized and directed bench for the two-entry registered-ready skid buffer.
// A queue model (contents = words held, in order) predicts every output.
module tb_fcb_2_skid_registered_rdy;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_vld;
    logic       down_rdy;
    logic [7:0] up_data;

    logic       up_rdy8, down_vld8;
    logic [7:0] down_data8;
    logic [1:0] occ8;
    logic       up_rdy1, down_vld1;
    logic [0:0] down_data1;
    logic [1:0] occ1;

    always #5 clk = ~clk;

    fcb_2_skid_registered_rdy #(.w(8)) dut8 (
        .clk(clk), .rst(rst),
        .up_vld(up_vld), .up_rdy(up_rdy8), .up_data(up_data),
        .down_vld(down_vld8), .down_rdy(down_rdy), .down_data(down_data8),
        .occupancy(occ8)
    );

    fcb_2_skid_registered_rdy #(.w(1)) dut1 (
        .clk(clk), .rst(rst),
        .up_vld(up_vld), .up_rdy(up_rdy1), .up_data(up_data[0:0]),
        .down_vld(down_vld1), .down_rdy(down_rdy), .down_data(down_data1),
        .occupancy(occ1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of at most two words ----------------
    logic [7:0] q8[$];
    logic       q1[$];
    int         n_in = 0, n_drop = 0, n_out8 = 0, n_out1 = 0;
    bit         stall_prev = 0;
    logic [7:0] data_prev;

    always @(posedge clk or posedge rst) begin
        bit acc, pop;
        if (rst) begin
            n_drop += q8.size();
            q8.delete();
            q1.delete();
            stall_prev = 0;
        end else begin
            acc = up_vld && (q8.size() < 2);
            pop = (q8.size() > 0) && down_rdy;
            if (down_vld8 && down_rdy) n_out8++;
            if (down_vld1 && down_rdy) n_out1++;
            stall_prev = down_vld8 && !down_rdy;
            data_prev  = down_data8;
            if (pop) begin
                void'(q8.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                q8.push_back(up_data);
                q1.push_back(up_data[0]);
                n_in++;
            end
        end
    end

    // Compare process: outputs are registered, so check them mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("vld8", {31'd0, down_vld8}, {31'd0, q8.size() > 0});
            check("rdy8", {31'd0, up_rdy8},   {31'd0, q8.size() < 2});
            check("occ8", {30'd0, occ8},      q8.size());
            if (q8.size() > 0) check("data8", {24'd0, down_data8}, {24'd0, q8[0]});
            check("vld1", {31'd0, down_vld1}, {31'd0, q1.size() > 0});
            check("rdy1", {31'd0, up_rdy1},   {31'd0, q1.size() < 2});
            check("occ1", {30'd0, occ1},      q1.size());
            if (q1.size() > 0) check("data1", {31'd0, down_data1}, {31'd0, q1[0]});
            if (stall_prev) check("stable8", {24'd0, down_data8}, {24'd0, data_prev});
        end
    end

    // Advance one cycle; inputs change just after the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int acc, cycles;
        rst = 1'b1; up_vld = 1'b0; down_rdy = 1'b0; up_data = 8'h00;
        #12;
        check("rst_vld", {31'd0, down_vld8}, 32'd0);
        check("rst_rdy", {31'd0, up_rdy8},   32'd1);
        check("rst_occ", {30'd0, occ8},      32'd0);
        check("rst_data", {24'd0, down_data8}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // 1: streaming at full rate
        down_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            up_vld = 1'b1; up_data = 8'(i);
            if (i == 2) check("t1_first", {24'd0, down_data8}, 32'h01);
            cyc();
        end
        up_vld = 1'b0;
        cyc(); cyc();
        check("t1_count", n_out8, 32'd16);

        // 2: stall fills main and skid
        down_rdy = 1'b0; up_vld = 1'b1;
        up_data = 8'hA0; cyc();
        up_data = 8'hA1; cyc();
        up_data = 8'hA2; cyc();
        check("t2_data", {24'd0, down_data8}, 32'hA0);
        check("t2_occ",  {30'd0, occ8},       32'd2);
        check("t2_rdy",  {31'd0, up_rdy8},    32'd0);

        // 6: mid-cycle down_rdy toggles do not reach up_rdy
        down_rdy = 1'b1; #1;
        check("t6_rdy_hi", {31'd0, up_rdy8}, 32'd0);
        down_rdy = 1'b0; #1;
        check("t6_rdy_lo", {31'd0, up_rdy8}, 32'd0);

        // 3: one-cycle ready pulse from FULL
        down_rdy = 1'b1; cyc();
        down_rdy = 1'b0;
        check("t3_occ",  {30'd0, occ8},       32'd1);
        check("t3_rdy",  {31'd0, up_rdy8},    32'd1);
        check("t3_data", {24'd0, down_data8}, 32'hA1);
        cyc();                              // 0xA2 finally accepted
        up_vld = 1'b0; down_rdy = 1'b1;
        cyc(); cyc(); cyc();

        // 5: asynchronous reset while FULL with 0x55, 0x66
        down_rdy = 1'b0; up_vld = 1'b1;
        up_data = 8'h55; cyc();
        up_data = 8'h66; cyc();
        up_vld = 1'b0;
        check("t5_full", {30'd0, occ8}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t5_vld", {31'd0, down_vld8}, 32'd0);
        check("t5_rdy", {31'd0, up_rdy8},   32'd1);
        check("t5_occ", {30'd0, occ8},      32'd0);
        check("t5_drop", n_drop, 32'd2);
        up_vld = 1'b1;                      // handshake attempt under reset
        cyc(); cyc();
        up_vld = 1'b0; rst = 1'b0;
        down_rdy = 1'b1;
        cyc(); cyc(); cyc();

        // 4: random traffic, 10k accepted words
        acc = 0; cycles = 0;
        while (acc < 10000 && cycles < 60000) begin
            up_vld   = 1'($urandom_range(0, 1));
            down_rdy = 1'($urandom_range(0, 1));
            up_data  = 8'($urandom);
            if (up_vld && up_rdy8) acc++;
            cyc();
            cycles++;
        end
        check("t4_budget", {31'd0, acc >= 10000}, 32'd1);
        up_vld = 1'b0; down_rdy = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        check("t4_empty", {30'd0, occ8}, 32'd0);
        check("t4_cons8", n_out8, n_in - n_drop);
        check("t4_cons1", n_out1, n_in - n_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
